// File: rtl/lc3_alu_sequencer.sv
// LC-3 ALU sequencer: fetches operands for ADD/AND/NOT, strobes the ALU, writes back and updates NZP.
// Latency: handshake cycle 0, READ 1, EXEC 2, WB 3, ready again cycle 4 (illegal opcode: ready at cycle 2).
// Backpressure: instr_ready is high only in IDLE; instr_valid/instr are ignored while an operation is in flight.
// Optional feature: define LC3_ALU_CARRY_FLAG_EN to register the ALU carry into carry_flag at write-back.
module lc3_alu_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [2:0]  sr1_addr,
    output logic [2:0]  sr2_addr,
    input  logic [15:0] sr1_data,
    input  logic [15:0] sr2_data,
    output logic [15:0] aluin1,
    output logic [15:0] aluin2,
    output logic [1:0]  alu_control,
    output logic        enable_execute,
    input  logic [15:0] aluout,
    input  logic        alucarry,
    output logic        wb_en,
    output logic [2:0]  wb_addr,
    output logic [15:0] wb_data,
    output logic [2:0]  nzp,
    output logic        carry_flag,
    output logic        illegal
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_AND = 2'd1;
    localparam logic [1:0] ALU_NOT = 2'd3;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] instr_q;
    logic        accept;

    logic [3:0]  opcode;
    logic        is_add;
    logic        is_and;
    logic        is_not;
    logic        legal;
    logic [15:0] imm5_sext;
    logic [15:0] operand2;
    logic [1:0]  alu_op;

    assign accept = instr_valid && instr_ready;

    // Field decode of the latched instruction; the live instr bus is never looked at after the handshake.
    always_comb begin
        opcode    = instr_q[15:12];
        is_add    = (opcode == OP_ADD);
        is_and    = (opcode == OP_AND);
        is_not    = (opcode == OP_NOT);
        legal     = is_add || is_and || is_not;
        imm5_sext = {{11{instr_q[4]}}, instr_q[4:0]};
        alu_op    = ALU_ADD;
        operand2  = sr2_data;
        if (is_not) begin
            alu_op   = ALU_NOT;
            operand2 = 16'h0000;
        end else begin
            alu_op   = is_and ? ALU_AND : ALU_ADD;
            operand2 = instr_q[5] ? imm5_sext : sr2_data;
        end
    end

    assign sr1_addr = instr_q[8:6];
    assign sr2_addr = instr_q[2:0];
    assign wb_addr  = instr_q[11:9];
    assign wb_data  = aluout;

    // State register; reset wins over a same-cycle handshake and aborts any operation in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and the per-state strobes.
    always_comb begin
        state_nxt      = state;
        instr_ready    = 1'b0;
        enable_execute = 1'b0;
        wb_en          = 1'b0;
        illegal        = 1'b0;
        unique case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                if (legal) begin
                    state_nxt = EXEC;
                end else begin
                    illegal   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            EXEC: begin
                enable_execute = 1'b1;
                state_nxt      = WB;
            end
            WB: begin
                wb_en     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the instruction only on an accepted handshake so later bus activity cannot disturb it.
    always_ff @(posedge clock) begin
        if (reset) begin
            instr_q <= 16'h0000;
        end else if (accept) begin
            instr_q <= instr;
        end
    end

    // Operand and opcode registers, loaded at the end of READ for legal instructions only.
    always_ff @(posedge clock) begin
        if (reset) begin
            aluin1      <= 16'h0000;
            aluin2      <= 16'h0000;
            alu_control <= ALU_ADD;
        end else if (state == READ && legal) begin
            aluin1      <= sr1_data;
            aluin2      <= operand2;
            alu_control <= alu_op;
        end
    end

    // Condition codes follow the written-back value; they hold across idle and illegal cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            nzp <= 3'b010;
        end else if (state == WB) begin
            if (aluout[15]) begin
                nzp <= 3'b100;
            end else if (aluout == 16'h0000) begin
                nzp <= 3'b010;
            end else begin
                nzp <= 3'b001;
            end
        end
    end

`ifdef LC3_ALU_CARRY_FLAG_EN
    // Carry is sampled alongside the condition codes at the end of write-back.
    always_ff @(posedge clock) begin
        if (reset) begin
            carry_flag <= 1'b0;
        end else if (state == WB) begin
            carry_flag <= alucarry;
        end
    end
`else
    logic unused_alucarry;
    assign unused_alucarry = alucarry;
    assign carry_flag      = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_alu_sequencer.sv
// Randomized bench for lc3_alu_sequencer: external register file and ALU models plus an
// instruction-level reference model (own register copy, NZP and carry) checked cycle by cycle.
// Directed vectors cover the documented examples, an illegal opcode, and reset during EXEC / with a handshake.
module tb_lc3_alu_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [2:0]  sr1_addr;
    logic [2:0]  sr2_addr;
    logic [15:0] sr1_data;
    logic [15:0] sr2_data;
    logic [15:0] aluin1;
    logic [15:0] aluin2;
    logic [1:0]  alu_control;
    logic        enable_execute;
    logic [15:0] aluout;
    logic        alucarry;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic [2:0]  nzp;
    logic        carry_flag;
    logic        illegal;

    lc3_alu_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .sr1_addr       (sr1_addr),
        .sr2_addr       (sr2_addr),
        .sr1_data       (sr1_data),
        .sr2_data       (sr2_data),
        .aluin1         (aluin1),
        .aluin2         (aluin2),
        .alu_control    (alu_control),
        .enable_execute (enable_execute),
        .aluout         (aluout),
        .alucarry       (alucarry),
        .wb_en          (wb_en),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .nzp            (nzp),
        .carry_flag     (carry_flag),
        .illegal        (illegal)
    );

    always #5 clock = ~clock;

    // Environment: register file with combinational reads, plus a preload port for the bench.
    logic [15:0] rf [8];
    logic        pl_en;
    logic [2:0]  pl_addr;
    logic [15:0] pl_val;

    assign sr1_data = rf[sr1_addr];
    assign sr2_data = rf[sr2_addr];

    always @(posedge clock) begin
        if (wb_en) rf[wb_addr] <= wb_data;
        else if (pl_en) rf[pl_addr] <= pl_val;
    end

    // Environment: registered ALU, result valid the cycle after enable_execute.
    always @(posedge clock) begin
        if (enable_execute) begin
            case (alu_control)
                2'd0:    {alucarry, aluout} <= {1'b0, aluin1} + {1'b0, aluin2};
                2'd1:    {alucarry, aluout} <= {1'b0, aluin1 & aluin2};
                2'd3:    {alucarry, aluout} <= {1'b0, ~aluin1};
                default: {alucarry, aluout} <= 17'h0;
            endcase
        end
    end

    // Reference model state.
    logic [15:0] ref_rf [8];
    logic [2:0]  ref_nzp;
    logic        ref_carry;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_reg(input logic [2:0] a, input logic [15:0] v);
        @(negedge clock);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_val  = v;
        ref_rf[a] = v;
        @(negedge clock);
        pl_en = 1'b0;
    endtask

    function automatic logic [2:0] nzp_of(input logic [15:0] v);
        if (v[15]) return 3'b100;
        if (v == 16'h0) return 3'b010;
        return 3'b001;
    endfunction

    // Issue one instruction and check every cycle of its life against the reference model.
    task automatic run_instr(input logic [15:0] ins);
        int          op;
        int          a;
        int          b;
        int          sum;
        logic [15:0] exp_b;
        logic [15:0] exp_res;
        logic [1:0]  exp_ctl;
        logic        exp_cy;
        logic        is_legal;
        logic [2:0]  dst;
        op  = int'(ins[15:12]);
        dst = ins[11:9];
        a   = int'(ref_rf[ins[8:6]]);
        is_legal = (op == 1) || (op == 5) || (op == 9);
        if (ins[5]) exp_b = {{11{ins[4]}}, ins[4:0]};
        else        exp_b = ref_rf[ins[2:0]];
        exp_cy = 1'b0;
        exp_ctl = 2'd0;
        exp_res = 16'h0;
        if (op == 9) begin
            exp_b   = 16'h0;
            exp_ctl = 2'd3;
            exp_res = 16'hFFFF - 16'(a);
        end else if (op == 5) begin
            exp_ctl = 2'd1;
            exp_res = 16'(a) & exp_b;
        end else begin
            b       = int'(exp_b);
            sum     = a + b;
            exp_res = 16'(sum % 65536);
            exp_cy  = (sum >= 65536);
        end
`ifndef LC3_ALU_CARRY_FLAG_EN
        exp_cy = 1'b0;
`endif

        @(negedge clock);
        check("ready_idle", instr_ready, 1);
        instr_valid = 1'b1;
        instr       = ins;
        @(negedge clock);
        // cycle 1: READ; scramble the bus to prove it is not re-sampled
        instr_valid = 1'($urandom_range(0, 1));
        instr       = 16'($urandom);
        check("illegal_c1", illegal, 32'(!is_legal));
        check("ready_c1", instr_ready, 0);
        check("exec_c1", enable_execute, 0);
        check("wb_c1", wb_en, 0);
        check("sr1_addr", sr1_addr, 32'(ins[8:6]));
        check("sr2_addr", sr2_addr, 32'(ins[2:0]));
        if (!is_legal) begin
            @(negedge clock);
            instr_valid = 1'b0;
            check("ill_ready_c2", instr_ready, 1);
            check("ill_exec_c2", enable_execute, 0);
            check("ill_wb_c2", wb_en, 0);
            check("ill_pulse_c2", illegal, 0);
            check("ill_nzp", nzp, 32'(ref_nzp));
            return;
        end
        @(negedge clock);
        // cycle 2: EXEC
        check("exec_c2", enable_execute, 1);
        check("aluin1", aluin1, 32'(a));
        check("aluin2", aluin2, 32'(exp_b));
        check("alu_control", alu_control, 32'(exp_ctl));
        check("wb_c2", wb_en, 0);
        @(negedge clock);
        // cycle 3: WB
        check("wb_c3", wb_en, 1);
        check("wb_addr", wb_addr, 32'(dst));
        check("wb_data", wb_data, 32'(exp_res));
        check("exec_c3", enable_execute, 0);
        check("ready_c3", instr_ready, 0);
        check("nzp_hold_c3", nzp, 32'(ref_nzp));
        instr_valid = 1'b0;
        @(negedge clock);
        // cycle 4: back in IDLE with flags and register updated
        ref_rf[dst] = exp_res;
        ref_nzp     = nzp_of(exp_res);
        ref_carry   = exp_cy;
        check("ready_c4", instr_ready, 1);
        check("wb_c4", wb_en, 0);
        check("nzp", nzp, 32'(ref_nzp));
        check("carry_flag", carry_flag, 32'(ref_carry));
        check("rf_dst", rf[dst], 32'(ref_rf[dst]));
    endtask

    initial begin
        logic [15:0] ins;
        logic [3:0]  op;
        int          kind;
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = 16'h0;
        pl_en       = 1'b0;
        pl_addr     = 3'd0;
        pl_val      = 16'h0;
        ref_nzp     = 3'b010;
        ref_carry   = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_ready", instr_ready, 1);
        check("rst_aluin1", aluin1, 0);
        check("rst_aluin2", aluin2, 0);
        check("rst_ctl", alu_control, 0);
        check("rst_exec", enable_execute, 0);
        check("rst_wb", wb_en, 0);
        check("rst_illegal", illegal, 0);
        check("rst_nzp", nzp, 3'b010);
        check("rst_carry", carry_flag, 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) set_reg(3'(i), 16'($urandom));

        // documented examples
        set_reg(3'd0, 16'h0005);
        set_reg(3'd1, 16'h0003);
        run_instr(16'h1401);
        check("ex_add_r2", rf[2], 16'h0008);
        check("ex_add_nzp", nzp, 3'b001);
        set_reg(3'd1, 16'h0000);
        run_instr(16'h127F);
        check("ex_dec_r1", rf[1], 16'hFFFF);
        check("ex_dec_nzp", nzp, 3'b100);
        set_reg(3'd5, 16'hFFFF);
        run_instr(16'h1961);
        check("ex_wrap_r4", rf[4], 16'h0000);
        check("ex_wrap_nzp", nzp, 3'b010);
`ifdef LC3_ALU_CARRY_FLAG_EN
        check("ex_wrap_carry", carry_flag, 1);
`else
        check("ex_wrap_carry", carry_flag, 0);
`endif
        set_reg(3'd2, 16'h00FF);
        run_instr(16'h96BF);
        check("ex_not_r3", rf[3], 16'hFF00);
        run_instr(16'h0000);
        check("ex_ill_nzp", nzp, 3'b100);

        // reset during EXEC aborts the write-back
        set_reg(3'd0, 16'h0005);
        set_reg(3'd1, 16'h0003);
        set_reg(3'd2, 16'h1234);
        @(negedge clock);
        instr_valid = 1'b1;
        instr       = 16'h1401;
        @(negedge clock);
        instr_valid = 1'b0;
        @(negedge clock);
        check("mid_exec", enable_execute, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        ref_nzp   = 3'b010;
        ref_carry = 1'b0;
        check("mid_wb", wb_en, 0);
        check("mid_ready", instr_ready, 1);
        check("mid_nzp", nzp, 3'b010);
        check("mid_carry", carry_flag, 0);
        check("mid_aluin1", aluin1, 0);
        @(negedge clock);
        check("mid_wb_after", wb_en, 0);
        check("mid_r2", rf[2], 16'h1234);

        // reset wins over a same-cycle handshake
        @(negedge clock);
        reset       = 1'b1;
        instr_valid = 1'b1;
        instr       = 16'h1401;
        @(negedge clock);
        reset       = 1'b0;
        instr_valid = 1'b0;
        check("prio_ready", instr_ready, 1);
        @(negedge clock);
        check("prio_still_idle", instr_ready, 1);
        check("prio_no_illegal", illegal, 0);

        // randomized traffic
        for (int i = 0; i < 200; i++) begin
            if ((i % 8) == 0) begin
                kind = $urandom_range(0, 3);
                case (kind)
                    0:       set_reg(3'($urandom), 16'h0000);
                    1:       set_reg(3'($urandom), 16'hFFFF);
                    2:       set_reg(3'($urandom), 16'h8000);
                    default: set_reg(3'($urandom), 16'($urandom));
                endcase
            end
            kind = $urandom_range(0, 9);
            ins  = 16'($urandom);
            if (kind <= 2)      op = 4'b0001;
            else if (kind <= 5) op = 4'b0101;
            else if (kind <= 7) op = 4'b1001;
            else begin
                op = 4'($urandom);
                while (op == 4'b0001 || op == 4'b0101 || op == 4'b1001) op = 4'($urandom);
            end
            ins[15:12] = op;
            run_instr(ins);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
